// File: rtl/decoder_pkg.sv
// Types and helpers shared by the one-hot decoder/pulser and its FIFO.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int CNT_W      = 8;
  localparam int MAX_CODE_W = 8;
  localparam int MAX_OUT_W  = 2 ** MAX_CODE_W;

  // Widest decode; callers truncate to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot_of(input logic [MAX_CODE_W-1:0] code);
    logic [MAX_OUT_W-1:0] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/onehot_decoder_pulser_if.sv
// Code handshake, enable and strobe outputs of the decoder/pulser.
interface onehot_decoder_pulser_if #(
  parameter int CODE_W = 3,
  parameter int DEPTH  = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CODE_W-1:0]         in_code;
  logic                      en;
  logic [(2**CODE_W)-1:0]    y_onehot;
  logic                      busy;
  logic                      done;
  logic [$clog2(DEPTH):0]    fifo_count;

  modport master (
    output in_valid, in_code, en,
    input  in_ready, y_onehot, busy, done, fifo_count
  );

  modport slave (
    input  in_valid, in_code, en,
    output in_ready, y_onehot, busy, done, fifo_count
  );
endinterface

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO; the head is readable in the cycle after a push.
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Full comes from the registered count only, so a same-cycle pop never frees a slot.
  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/onehot_decoder_pulser.sv
// Replays queued codes as registered one-hot strobes of PULSE_LEN cycles,
// each followed by GAP_LEN all-zero cycles; en low freezes the sequencer.
module onehot_decoder_pulser
  import decoder_pkg::*;
#(
  parameter int CODE_W    = 3,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int DEPTH     = 4
) (
  input logic                    clk,
  input logic                    rst,
  onehot_decoder_pulser_if.slave bus
);
  localparam int OUT_W = 2 ** CODE_W;
  localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [OUT_W-1:0]       y_reg, y_next;
  logic                   load;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CODE_W-1:0]      head_code;
  logic [$clog2(DEPTH):0] fifo_count;

  sync_fifo #(
    .WIDTH(CODE_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (bus.in_valid),
    .din  (bus.in_code),
    .pop  (load),
    .dout (head_code),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      y_reg     <= y_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    y_next     = y_reg;
    load       = 1'b0;
    if (bus.en) begin
      unique case (state_reg)
        IDLE: load = !fifo_empty;
        PULSE: begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
          end else if (GAP_LEN > 0) begin
            state_next = GAP;
            y_next     = '0;
            cnt_next   = GAP_INIT;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
            y_next     = '0;
          end
        end
        GAP: begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - 1'b1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
            y_next     = '0;
          end
        end
        default: begin
          state_next = IDLE;
          y_next     = '0;
          cnt_next   = '0;
        end
      endcase
      // Every path that starts a strobe pops the head in the same cycle.
      if (load) begin
        state_next = PULSE;
        y_next     = OUT_W'(onehot_of(MAX_CODE_W'(head_code)));
        cnt_next   = PULSE_INIT;
      end
    end
  end

  assign bus.y_onehot   = bus.en ? y_reg : '0;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = bus.en && (state_reg == PULSE) && (cnt_reg == '0);
  assign bus.in_ready   = !fifo_full;
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_onehot_decoder_pulser.sv
// Scoreboard bench: expected strobes are queued at accept time and retired on done.
module tb_onehot_decoder_pulser;
  localparam int PULSE_LEN = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] sb_q [$];

  onehot_decoder_pulser_if #(.CODE_W(3), .DEPTH(4)) bus_a ();
  onehot_decoder_pulser_if #(.CODE_W(3), .DEPTH(4)) bus_b ();

  onehot_decoder_pulser #(.CODE_W(3), .PULSE_LEN(PULSE_LEN), .GAP_LEN(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  onehot_decoder_pulser #(.CODE_W(3), .PULSE_LEN(PULSE_LEN), .GAP_LEN(0), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Strobe monitor for dut_a: value, hold, width and the zero gap after done.
  logic       in_strobe = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] cur_y = '0;
  logic [7:0] exp_y;
  int         width = 0;
  int         n_strobes = 0;
  int         busy_total = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_strobe = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus_a.busy) busy_total++;
      if (prev_done) check("gap_zero", 32'(bus_a.y_onehot), 32'(0));
      if (bus_a.y_onehot != 8'h00) begin
        if (!in_strobe) begin
          in_strobe = 1'b1;
          width     = 0;
          cur_y     = bus_a.y_onehot;
        end else begin
          check("strobe_hold", 32'(bus_a.y_onehot), 32'(cur_y));
        end
        width++;
      end
      if (bus_a.done) begin
        check("done_with_strobe", 32'(in_strobe && (bus_a.y_onehot != 8'h00)), 32'(1));
        if (sb_q.size() == 0) begin
          check("sb_count_at_done", 32'(sb_q.size()), 32'(1));
        end else begin
          exp_y = sb_q.pop_front();
          check("strobe_value", 32'(cur_y), 32'(exp_y));
        end
        check("strobe_width", 32'(width), 32'(PULSE_LEN));
        n_strobes++;
        $display("strobe %0d: y=%02h width=%0d at %0t", n_strobes, cur_y, width, $time);
        in_strobe = 1'b0;
      end
      prev_done = bus_a.done;
    end
  end

  task automatic push_a(input logic [2:0] code, output int waits);
    logic [7:0] e;
    waits = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_code  = code;
    @(negedge clk);
    while (!bus_a.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!bus_a.in_ready) begin
      check("push_ready_timeout", 32'(bus_a.in_ready), 32'(1));
    end else begin
      e       = '0;
      e[code] = 1'b1;
      sb_q.push_back(e);
      $display("push code %0d expect %02h at %0t", code, e, $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((bus_a.busy || bus_a.fifo_count != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(bus_a.busy || (bus_a.fifo_count != 0)), 32'(0));
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          waits;
    int          busy_start;
    int          nz;
    int          dn;
    logic [2:0]  backlog [4] = '{3'd0, 3'd7, 3'd3, 3'd3};
    logic [2:0]  fill    [4] = '{3'd1, 3'd4, 3'd6, 3'd2};
    logic [7:0]  ey;

    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_code = '0; bus_a.en = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_code = '0; bus_b.en = 1'b1;
    #2;
    check("rst_y",        32'(bus_a.y_onehot),   32'(0));
    check("rst_busy",     32'(bus_a.busy),       32'(0));
    check("rst_done",     32'(bus_a.done),       32'(0));
    check("rst_in_ready", 32'(bus_a.in_ready),   32'(1));
    check("rst_count",    32'(bus_a.fifo_count), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single code 5: strobe in cycles 2..5, done in 5, busy low from 7.
    busy_start = busy_total;
    push_a(3'd5, waits);
    bus_a.in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      ey = (k >= 2 && k <= 5) ? 8'h20 : 8'h00;
      check("single_y",    32'(bus_a.y_onehot), 32'(ey));
      check("single_done", 32'(bus_a.done),     32'(k == 5));
      check("single_busy", 32'(bus_a.busy),     32'(k >= 2 && k <= 6));
      @(posedge clk); #1;
    end
    wait_idle("single");
    check("single_busy_cycles", 32'(busy_total - busy_start), 32'(5));

    // Backlog with valid held high: period of PULSE_LEN+GAP_LEN per code.
    busy_start = busy_total;
    for (int i = 0; i < 4; i++) begin
      push_a(backlog[i], waits);
      check("backlog_ready_wait", 32'(waits), 32'(0));
    end
    bus_a.in_valid = 1'b0;
    wait_idle("backlog");
    check("backlog_busy_cycles", 32'(busy_total - busy_start), 32'(20));

    // Fill while paused, try two more, then drain in order.
    bus_a.en = 1'b0;
    for (int i = 0; i < 4; i++) push_a(fill[i], waits);
    @(negedge clk);
    check("full_in_ready", 32'(bus_a.in_ready),   32'(0));
    check("full_count",    32'(bus_a.fifo_count), 32'(4));
    check("paused_y",      32'(bus_a.y_onehot),   32'(0));
    check("paused_busy",   32'(bus_a.busy),       32'(0));
    bus_a.in_valid = 1'b1;
    bus_a.in_code  = 3'd5;
    @(negedge clk);
    check("reject5_ready", 32'(bus_a.in_ready),   32'(0));
    check("reject5_count", 32'(bus_a.fifo_count), 32'(4));
    bus_a.in_code = 3'd7;
    @(negedge clk);
    check("reject6_count", 32'(bus_a.fifo_count), 32'(4));
    bus_a.in_valid = 1'b0;
    @(posedge clk); #1;
    bus_a.en = 1'b1;
    @(negedge clk);
    check("pop_cycle_ready", 32'(bus_a.in_ready), 32'(0));
    wait_idle("drain");

    // Pause for 3 cycles after the 2nd strobe cycle.
    busy_start = busy_total;
    push_a(3'd2, waits);
    bus_a.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      bus_a.en = !(k >= 4 && k <= 6);
      @(negedge clk);
      ey = (k == 2 || k == 3 || k == 7 || k == 8) ? 8'h04 : 8'h00;
      check("pause_y",    32'(bus_a.y_onehot), 32'(ey));
      check("pause_done", 32'(bus_a.done),     32'(k == 8));
      @(posedge clk); #1;
    end
    bus_a.en = 1'b1;
    wait_idle("pause");
    check("pause_busy_cycles", 32'(busy_total - busy_start), 32'(8));

    // Asynchronous reset in the 2nd strobe cycle with two codes queued.
    push_a(3'd3, waits);
    push_a(3'd6, waits);
    push_a(3'd1, waits);
    bus_a.in_valid = 1'b0;
    check("prerst_y",     32'(bus_a.y_onehot),   32'(8'h08));
    check("prerst_count", 32'(bus_a.fifo_count), 32'(2));
    #1 rst = 1'b1;
    #1;
    sb_q.delete();
    check("midrst_y",     32'(bus_a.y_onehot),   32'(0));
    check("midrst_busy",  32'(bus_a.busy),       32'(0));
    check("midrst_done",  32'(bus_a.done),       32'(0));
    check("midrst_count", 32'(bus_a.fifo_count), 32'(0));
    check("midrst_ready", 32'(bus_a.in_ready),   32'(1));
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    nz = 0;
    dn = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus_a.y_onehot != 8'h00) nz++;
      if (bus_a.done) dn++;
    end
    check("postrst_strobes", 32'(nz), 32'(0));
    check("postrst_done",    32'(dn), 32'(0));
    check("postrst_count",   32'(bus_a.fifo_count), 32'(0));
    @(posedge clk); #1;

    // GAP_LEN=0: codes 1 and 2 back-to-back with no zero cycle.
    bus_b.in_valid = 1'b1;
    bus_b.in_code  = 3'd1;
    @(negedge clk);
    check("b2b_ready0", 32'(bus_b.in_ready), 32'(1));
    @(posedge clk); #1;
    bus_b.in_code = 3'd2;
    @(negedge clk);
    check("b2b_ready1", 32'(bus_b.in_ready), 32'(1));
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      ey = (k <= 5) ? 8'h02 : ((k <= 9) ? 8'h04 : 8'h00);
      check("b2b_y",    32'(bus_b.y_onehot), 32'(ey));
      check("b2b_done", 32'(bus_b.done),     32'(k == 5 || k == 9));
      check("b2b_busy", 32'(bus_b.busy),     32'(k <= 9));
      $display("b2b cycle %0d: y=%02h done=%0d", k, bus_b.y_onehot, bus_b.done);
      @(posedge clk); #1;
    end

    check("final_sb_empty", 32'(sb_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
